// File: rtl/stack_upstream_collector_pkg.sv
// Shared definitions for the stack-bus upstream collector: cntl encodings, FSM states, widths.
package stack_upstream_collector_pkg;

    localparam int unsigned NUM_PE_DEF     = 4;
    localparam int unsigned PEID_W_DEF     = 2;
    localparam int unsigned TYPE_W_DEF     = 2;
    localparam int unsigned DATA_W_DEF     = 64;
    localparam int unsigned OOB_W_DEF      = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } state_e;

endpackage

// File: rtl/stack_upstream_collector_fifo.sv
// Synchronous FIFO with registered pointers; a push is refused while full even if a pop
// happens in the same cycle.
module stack_upstream_collector_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/stack_upstream_collector.sv
// Round-robin, packet-granular collector of PE upstream streams onto one stack-bus channel.
// Optional cntl-sequence checking is enabled by defining STACK_UPSTREAM_COLLECTOR_CHECK_EN.
module stack_upstream_collector
    import stack_upstream_collector_pkg::*;
#(
    parameter int unsigned NUM_PE     = NUM_PE_DEF,
    parameter int unsigned PEID_W     = PEID_W_DEF,
    parameter int unsigned TYPE_W     = TYPE_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned OOB_W      = OOB_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset_poweron,
    input  logic [NUM_PE-1:0]       pe__stu__valid,
    input  logic [2*NUM_PE-1:0]     pe__stu__cntl,
    input  logic [TYPE_W*NUM_PE-1:0] pe__stu__type,
    input  logic [DATA_W*NUM_PE-1:0] pe__stu__data,
    input  logic [OOB_W*NUM_PE-1:0] pe__stu__oob_data,
    output logic [NUM_PE-1:0]       stu__pe__ready,
    output logic                    stu__stk__valid,
    output logic [1:0]              stu__stk__cntl,
    output logic [TYPE_W-1:0]       stu__stk__type,
    output logic [DATA_W-1:0]       stu__stk__data,
    output logic [OOB_W-1:0]        stu__stk__oob_data,
    output logic [PEID_W-1:0]       stu__stk__peId,
    input  logic                    stk__stu__ready,
    output logic [NUM_PE-1:0]       stu__sys__err
);

    localparam int unsigned ENTRY_W = 2 + TYPE_W + DATA_W + OOB_W + PEID_W;

    state_e              state_q, state_d;
    logic [PEID_W-1:0]   grant_q, grant_d;
    logic [PEID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic                sel_valid;
    logic [1:0]          sel_cntl;
    logic [TYPE_W-1:0]   sel_type;
    logic [DATA_W-1:0]   sel_data;
    logic [OOB_W-1:0]    sel_oob;

    logic [2*NUM_PE-1:0] valid_dbl;
    logic [NUM_PE-1:0]   valid_rot;
    logic                found;
    logic [PEID_W-1:0]   pick_off;
    logic [PEID_W:0]     pick_sum;
    logic [PEID_W-1:0]   pick;
    logic [PEID_W:0]     rr_next;

    logic                fifo_full, fifo_empty;
    logic                accept, beat_ok, push, is_end;
    logic [ENTRY_W-1:0]  push_data, head;

    // Mux of the granted PE's stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_cntl  = '0;
        sel_type  = '0;
        sel_data  = '0;
        sel_oob   = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (grant_q == PEID_W'(i)) begin
                sel_valid = pe__stu__valid[i];
                sel_cntl  = pe__stu__cntl[2*i +: 2];
                sel_type  = pe__stu__type[TYPE_W*i +: TYPE_W];
                sel_data  = pe__stu__data[DATA_W*i +: DATA_W];
                sel_oob   = pe__stu__oob_data[OOB_W*i +: OOB_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            stu__pe__ready[i] = (state_q == StLocked) && (grant_q == PEID_W'(i)) && !fifo_full;
        end
    end

    // Rotate valids so bit 0 is rr_ptr, take the lowest set bit, then rotate back.
    assign valid_dbl = {pe__stu__valid, pe__stu__valid};

    always_comb begin
        valid_rot = NUM_PE'(valid_dbl >> rr_ptr_q);
        found     = 1'b0;
        pick_off  = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (!found && valid_rot[k]) begin
                found    = 1'b1;
                pick_off = PEID_W'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (PEID_W+1)'(NUM_PE)) begin
            pick_sum = pick_sum - (PEID_W+1)'(NUM_PE);
        end
        pick = pick_sum[PEID_W-1:0];

        rr_next = {1'b0, grant_q} + (PEID_W+1)'(1);
        if (rr_next == (PEID_W+1)'(NUM_PE)) begin
            rr_next = '0;
        end
    end

    assign accept    = (state_q == StLocked) && sel_valid && !fifo_full;
    assign is_end    = (sel_cntl == CNTL_EOM) || (sel_cntl == CNTL_SOM_EOM);
    assign push      = accept && beat_ok;
    assign push_data = {sel_cntl, sel_type, sel_data, sel_oob, grant_q};

`ifdef STACK_UPSTREAM_COLLECTOR_CHECK_EN
    logic              first_q, first_d;
    logic [NUM_PE-1:0] err_q, err_d;
    logic              is_start;

    assign is_start = (sel_cntl == CNTL_SOM) || (sel_cntl == CNTL_SOM_EOM);
    assign beat_ok  = first_q ? is_start : ((sel_cntl == CNTL_MOM) || (sel_cntl == CNTL_EOM));

    always_comb begin
        first_d = first_q;
        err_d   = err_q;
        if (state_q == StIdle && found) begin
            first_d = 1'b1;
        end
        if (push) begin
            first_d = 1'b0;
        end
        // Violating beats are consumed but flagged against the owning PE.
        if (accept && !beat_ok) begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (grant_q == PEID_W'(i)) begin
                    err_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            first_q <= 1'b0;
            err_q   <= '0;
        end else begin
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assign stu__sys__err = err_q;
`else
    assign beat_ok       = 1'b1;
    assign stu__sys__err = '0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (push && is_end) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next[PEID_W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    stack_upstream_collector_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push          (push),
        .push_data     (push_data),
        .pop           (stk__stu__ready),
        .pop_data      (head),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

    assign stu__stk__valid = !fifo_empty;
    assign {stu__stk__cntl, stu__stk__type, stu__stk__data, stu__stk__oob_data,
            stu__stk__peId} = head;

endmodule

// File: tb/tb_stack_upstream_collector.sv
// Directed bench for stack_upstream_collector: arbitration order, latency, backpressure,
// reset mid-packet, and cntl checking (STACK_UPSTREAM_COLLECTOR_CHECK_EN).
module tb_stack_upstream_collector;

    logic         clk;
    logic         reset_poweron;
    logic [3:0]   pe__stu__valid;
    logic [7:0]   pe__stu__cntl;
    logic [7:0]   pe__stu__type;
    logic [255:0] pe__stu__data;
    logic [127:0] pe__stu__oob_data;
    logic [3:0]   stu__pe__ready;
    logic         stu__stk__valid;
    logic [1:0]   stu__stk__cntl;
    logic [1:0]   stu__stk__type;
    logic [63:0]  stu__stk__data;
    logic [31:0]  stu__stk__oob_data;
    logic [1:0]   stu__stk__peId;
    logic         stk__stu__ready;
    logic [3:0]   stu__sys__err;

    int n_checks = 0;
    int n_errors = 0;

    int          len [4];
    int          npk [4];
    int          pos [4];
    int          pkt [4];
    logic [63:0] base [4];
    bit          auto_drv;
    logic [79:0] log_q [$];

    stack_upstream_collector dut (
        .clk                (clk),
        .reset_poweron      (reset_poweron),
        .pe__stu__valid     (pe__stu__valid),
        .pe__stu__cntl      (pe__stu__cntl),
        .pe__stu__type      (pe__stu__type),
        .pe__stu__data      (pe__stu__data),
        .pe__stu__oob_data  (pe__stu__oob_data),
        .stu__pe__ready     (stu__pe__ready),
        .stu__stk__valid    (stu__stk__valid),
        .stu__stk__cntl     (stu__stk__cntl),
        .stu__stk__type     (stu__stk__type),
        .stu__stk__data     (stu__stk__data),
        .stu__stk__oob_data (stu__stk__oob_data),
        .stu__stk__peId     (stu__stk__peId),
        .stk__stu__ready    (stk__stu__ready),
        .stu__sys__err      (stu__sys__err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] entry(input int peid, input logic [1:0] c, input logic [63:0] d);
        return {8'(peid), 6'd0, c, d};
    endfunction

    task automatic drive_pe(input int i);
        logic [1:0]  c;
        logic [63:0] d;
        if (pkt[i] < npk[i]) begin
            if (len[i] == 1)               c = 2'b11;
            else if (pos[i] == 0)          c = 2'b01;
            else if (pos[i] == len[i] - 1) c = 2'b10;
            else                           c = 2'b00;
            d = base[i] + 64'(pkt[i] * 16 + pos[i]);
            pe__stu__valid[i]            = 1'b1;
            pe__stu__cntl[2*i +: 2]      = c;
            pe__stu__type[2*i +: 2]      = 2'(i);
            pe__stu__data[64*i +: 64]    = d;
            pe__stu__oob_data[32*i +: 32] = d[31:0];
        end else begin
            pe__stu__valid[i] = 1'b0;
        end
    endtask

    task automatic start_pe(input int i, input int l, input int n, input logic [63:0] b);
        len[i] = l; npk[i] = n; pos[i] = 0; pkt[i] = 0; base[i] = b;
        drive_pe(i);
    endtask

    task automatic stop_all();
        for (int i = 0; i < 4; i++) begin
            npk[i] = 0; pos[i] = 0; pkt[i] = 0;
        end
        pe__stu__valid = '0;
    endtask

    // One clock: capture output transfers and advance PE streams on accepted beats.
    task automatic tick();
        logic [3:0] acc;
        acc = pe__stu__valid & stu__pe__ready;
        if (stu__stk__valid && stk__stu__ready) begin
            log_q.push_back(entry(int'(stu__stk__peId), stu__stk__cntl, stu__stk__data));
        end
        @(posedge clk);
        #1;
        if (auto_drv) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    pos[i]++;
                    if (pos[i] == len[i]) begin
                        pos[i] = 0;
                        pkt[i]++;
                    end
                    drive_pe(i);
                end
            end
        end
    endtask

    task automatic do_reset();
        stop_all();
        reset_poweron = 1'b1;
        tick();
        tick();
        reset_poweron = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && log_q.size() < n; k++) tick();
        check(tag, 80'(log_q.size()), 80'(n));
    endtask

    initial begin
        logic [1:0] c;
        pe__stu__valid = '0; pe__stu__cntl = '0; pe__stu__type = '0;
        pe__stu__data = '0; pe__stu__oob_data = '0;
        stk__stu__ready = 1'b1;
        auto_drv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            len[i] = 1; npk[i] = 0; pos[i] = 0; pkt[i] = 0; base[i] = '0;
        end

        // Reset state
        do_reset();
        check("rst_ready", 80'(stu__pe__ready), 80'(4'b0000));
        check("rst_valid", 80'(stu__stk__valid), 80'(0));
        check("rst_err", 80'(stu__sys__err), 80'(4'b0000));

        // Single PE2 SOM_EOM, latency 2
        start_pe(2, 1, 1, 64'h1234);
        tick();
        check("t1_ready_c1", 80'(stu__pe__ready), 80'(4'b0100));
        check("t1_valid_c1", 80'(stu__stk__valid), 80'(0));
        tick();
        check("t1_valid_c2", 80'(stu__stk__valid), 80'(1));
        check("t1_peid", 80'(stu__stk__peId), 80'(2));
        check("t1_cntl", 80'(stu__stk__cntl), 80'(2'b11));
        check("t1_data", 80'(stu__stk__data), 80'(64'h1234));
        check("t1_type", 80'(stu__stk__type), 80'(2));
        check("t1_oob", 80'(stu__stk__oob_data), 80'(32'h1234));
        check("t1_rr_ptr", 80'(dut.rr_ptr_q), 80'(3));
        check("t1_ready_idle", 80'(stu__pe__ready), 80'(4'b0000));
        tick();
        check("t1_valid_c3", 80'(stu__stk__valid), 80'(0));

        // PE0 and PE1 three-beat packets, no interleave
        do_reset();
        start_pe(0, 3, 1, 64'h100);
        start_pe(1, 3, 1, 64'h200);
        tick();
        check("t2_ready_c1", 80'(stu__pe__ready), 80'(4'b0001));
        tick();
        tick();
        check("t2_ready_c3", 80'(stu__pe__ready), 80'(4'b0001));
        tick();
        check("t2_ready_idle", 80'(stu__pe__ready), 80'(4'b0000));
        tick();
        check("t2_ready_pe1", 80'(stu__pe__ready), 80'(4'b0010));
        wait_log("t2_count", 6, 20);
        for (int k = 0; k < 6 && k < log_q.size(); k++) begin
            c = (k % 3 == 0) ? 2'b01 : (k % 3 == 2) ? 2'b10 : 2'b00;
            check($sformatf("t2_beat%0d", k), log_q[k],
                  entry(k / 3, c, 64'h100 * 64'(k / 3 + 1) + 64'(k % 3)));
        end

        // Backpressure: six-beat packet into a four-entry FIFO
        do_reset();
        stk__stu__ready = 1'b0;
        start_pe(3, 6, 1, 64'h300);
        repeat (5) tick();
        check("t3_accepted", 80'(pos[3]), 80'(4));
        check("t3_ready_full", 80'(stu__pe__ready), 80'(4'b0000));
        check("t3_valid", 80'(stu__stk__valid), 80'(1));
        repeat (2) tick();
        check("t3_hold_accepted", 80'(pos[3]), 80'(4));
        check("t3_hold_ready", 80'(stu__pe__ready), 80'(4'b0000));
        check("t3_head", 80'(stu__stk__data), 80'(64'h300));
        stk__stu__ready = 1'b1;
        wait_log("t3_count", 6, 30);
        for (int k = 0; k < 6 && k < log_q.size(); k++) begin
            c = (k == 0) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
            check($sformatf("t3_beat%0d", k), log_q[k], entry(3, c, 64'h300 + 64'(k)));
        end

        // Fairness: all PEs continuously valid with single-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) start_pe(i, 1, 2, 64'h1000 * 64'(i + 1));
        wait_log("t4_count", 8, 40);
        for (int k = 0; k < 8 && k < log_q.size(); k++) begin
            check($sformatf("t4_grant%0d", k), log_q[k],
                  entry(k % 4, 2'b11, 64'h1000 * 64'(k % 4 + 1) + 64'((k / 4) * 16)));
        end

        // Reset mid-packet with three entries queued
        do_reset();
        stk__stu__ready = 1'b0;
        start_pe(1, 6, 1, 64'h500);
        repeat (4) tick();
        check("t5_accepted", 80'(pos[1]), 80'(3));
        stop_all();
        reset_poweron = 1'b1;
        tick();
        reset_poweron = 1'b0;
        check("t5_rst_valid", 80'(stu__stk__valid), 80'(0));
        check("t5_rst_ready", 80'(stu__pe__ready), 80'(4'b0000));
        check("t5_rst_err", 80'(stu__sys__err), 80'(4'b0000));
        log_q.delete();
        stk__stu__ready = 1'b1;
        start_pe(2, 1, 1, 64'h700);
        start_pe(0, 1, 1, 64'h600);
        tick();
        check("t5_ready_pe0", 80'(stu__pe__ready), 80'(4'b0001));
        wait_log("t5_count", 2, 20);
        if (log_q.size() >= 2) begin
            check("t5_first", log_q[0], entry(0, 2'b11, 64'h600));
            check("t5_second", log_q[1], entry(2, 2'b11, 64'h700));
        end

        // PE1 starts with MOM, then SOM_EOM
        do_reset();
        auto_drv = 1'b0;
        pe__stu__valid = 4'b0010;
        pe__stu__cntl[3:2] = 2'b00;
        pe__stu__data[127:64] = 64'hAA;
        tick();
        check("t6_ready", 80'(stu__pe__ready), 80'(4'b0010));
        tick();
        pe__stu__cntl[3:2] = 2'b11;
        pe__stu__data[127:64] = 64'hBB;
`ifdef STACK_UPSTREAM_COLLECTOR_CHECK_EN
        check("t6_err", 80'(stu__sys__err), 80'(4'b0010));
`else
        check("t6_err", 80'(stu__sys__err), 80'(4'b0000));
`endif
        tick();
        pe__stu__valid = '0;
        tick();
        tick();
`ifdef STACK_UPSTREAM_COLLECTOR_CHECK_EN
        check("t6_err_sticky", 80'(stu__sys__err), 80'(4'b0010));
        check("t6_count", 80'(log_q.size()), 80'(1));
        if (log_q.size() >= 1) check("t6_beat0", log_q[0], entry(1, 2'b11, 64'hBB));
`else
        check("t6_err_sticky", 80'(stu__sys__err), 80'(4'b0000));
        check("t6_count", 80'(log_q.size()), 80'(2));
        if (log_q.size() >= 2) begin
            check("t6_beat0", log_q[0], entry(1, 2'b00, 64'hAA));
            check("t6_beat1", log_q[1], entry(1, 2'b11, 64'hBB));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
